// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: single-outstanding imem requests, prefetch FIFO
// of {pc, word} pairs toward decode, branch redirect with flush and discard.
//
// state     | meaning
// S_IDLE    | no request outstanding
// S_REQ     | request outstanding, returned word will be pushed
// S_DISCARD | request outstanding, returned word is dropped (redirected)
module fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    br_taken,
  input  logic [PC_W-1:0]         br_target,
  output logic                    imem_req,
  output logic [PC_W-1:0]         imem_addr,
  input  logic                    imem_ack,
  input  logic [INSTR_W-1:0]      imem_rdata,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [INSTR_W-1:0]      instr,
  output logic [PC_W-1:0]         instr_pc,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t               state;
  logic [PC_W-1:0]      fetch_pc;
  logic [PC_W-1:0]      pc_next;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_after;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [PC_W-1:0]      pc_mem   [DEPTH];
  logic [INSTR_W-1:0]   word_mem [DEPTH];
  logic                 ack;
  logic                 pop;
  logic                 push;
  logic                 room_after;

  assign ack         = imem_req & imem_ack;
  assign pop         = (count != '0) & instr_ready;
  assign push        = (state == S_REQ) & ack & ~br_taken;
  // occupancy once the returning word lands; decides whether to chain the next request
  assign count_after = count + CW'(1) - CW'(pop);
  assign room_after  = count_after < FULL;
  assign pc_next     = fetch_pc + PC_W'(1);

  assign instr_valid = (count != '0);
  assign instr       = word_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];
  assign fifo_count  = count;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      word_mem[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      if (br_taken) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end

      case (state)
        S_IDLE: begin
          if (br_taken) begin
            fetch_pc <= br_target;
          end else if (en && count < FULL) begin
            state     <= S_REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        S_REQ: begin
          if (br_taken) begin
            fetch_pc <= br_target;
            if (ack) begin
              state    <= S_IDLE;
              imem_req <= 1'b0;
            end else begin
              state <= S_DISCARD;
            end
          end else if (ack) begin
            fetch_pc <= pc_next;
            if (en && room_after) begin
              imem_addr <= pc_next;
            end else begin
              state    <= S_IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        S_DISCARD: begin
          if (br_taken) fetch_pc <= br_target;
          if (ack) begin
            state    <= S_IDLE;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with configurable ack delay,
// scoreboard of expected {pc, word} pops, and per-scenario directed checks.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, en, br_taken, instr_ready;
  logic [15:0] br_target;
  logic        imem_req, imem_ack, instr_valid;
  logic [15:0] imem_addr, imem_rdata, instr, instr_pc;
  logic [2:0]  fifo_count;

  logic        w_req, w_ack, w_valid;
  logic [15:0] w_addr, w_rdata, w_instr, w_pc;
  logic [2:0]  w_count;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cycle = 0;
  int          n_pops = 0;
  int          mem_delay = 0;
  bit          mem_auto = 1'b1;
  logic [15:0] exp_q[$];
  logic [15:0] req_log[$];
  int          req_cyc[$];
  int          pop_cyc[$];
  logic [15:0] mon_e;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(16), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .en(en), .br_taken(br_taken), .br_target(br_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .fifo_count(fifo_count)
  );

  // second instance exercising PC wrap; its memory always acks immediately
  assign w_ack   = w_req;
  assign w_rdata = mem_word(w_addr);

  fetch_unit #(.PC_W(16), .INSTR_W(16), .DEPTH(DEPTH), .RESET_PC(16'hFFFE)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .br_taken(br_taken), .br_target(br_target),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .instr_valid(w_valid), .instr_ready(instr_ready), .instr(w_instr), .instr_pc(w_pc),
    .fifo_count(w_count)
  );

  // memory model: ack after mem_delay idle cycles of a held request
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_auto) begin
        if (imem_req === 1'b1) begin
          if (wait_cnt >= mem_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
            wait_cnt   = 0;
          end else begin
            imem_ack = 1'b0;
            wait_cnt++;
          end
        end else begin
          imem_ack = 1'b0;
          wait_cnt = 0;
        end
      end
    end
  end

  // monitor: just before each rising edge, log handshakes and score pops
  initial begin
    forever begin
      @(negedge clk);
      #4;
      cycle++;
      if (rst === 1'b0) begin
        if (imem_req === 1'b1 && imem_ack === 1'b1) begin
          req_log.push_back(imem_addr);
          req_cyc.push_back(cycle);
        end
        if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
          n_pops++;
          pop_cyc.push_back(cycle);
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL pop_unexpected: instr_pc=%h instr=%h, required no output", instr_pc, instr);
          end else begin
            mon_e = exp_q.pop_front();
            if (instr_pc !== mon_e || instr !== mem_word(mon_e)) begin
              tests_failed++;
              $display("FAIL scoreboard: instr_pc=%h instr=%h, required pc=%h instr=%h",
                       instr_pc, instr, mon_e, mem_word(mon_e));
            end
          end
        end
        tests_run++;
        if (fifo_count > 3'(DEPTH)) begin
          tests_failed++;
          $display("FAIL fifo_bound: fifo_count=%0d, required <= %0d", fifo_count, DEPTH);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; br_taken = 1'b0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); req_log.delete(); req_cyc.delete(); pop_cyc.delete();
    n_pops = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (imem_req !== 1'b0)      begin tests_failed++; $display("FAIL reset_req: got %b want 0", imem_req); end
    tests_run++; if (imem_addr !== 16'h0000) begin tests_failed++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
    tests_run++; if (fifo_count !== 3'd0)    begin tests_failed++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    tests_run++; if (instr_valid !== 1'b0)   begin tests_failed++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    tests_run++; if (w_addr !== 16'hFFFE)    begin tests_failed++; $display("FAIL reset_pc_param: got %h want fffe", w_addr); end
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b0)      begin tests_failed++; $display("FAIL en_low_no_req: got %b want 0", imem_req); end
  endtask

  task automatic test_stream();
    do_reset();
    mem_delay = 0;
    for (int i = 0; i < 10; i++) exp_q.push_back(16'(i));
    en = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      tests_failed++; $display("FAIL stream_first_req: req=%b addr=%h want 1/0000", imem_req, imem_addr); end
    repeat (9) @(negedge clk);
    en = 1'b0;
    repeat (8) @(negedge clk);
    tests_run++; if (req_log.size() != 10) begin
      tests_failed++; $display("FAIL stream_nreq: got %0d want 10", req_log.size()); end
    for (int i = 0; i < req_log.size(); i++) begin
      tests_run++;
      if (req_log[i] !== 16'(i) || req_cyc[i] != req_cyc[0] + i) begin
        tests_failed++; $display("FAIL stream_addr_seq[%0d]: addr=%h cyc_off=%0d want %h/%0d", i, req_log[i], req_cyc[i] - req_cyc[0], 16'(i), i); end
    end
    tests_run++; if (pop_cyc.size() != 10 || req_cyc.size() == 0 || pop_cyc[0] != req_cyc[0] + 1) begin
      tests_failed++; $display("FAIL stream_latency: pops=%0d want 10 with first pop 1 cycle after first ack", pop_cyc.size()); end
    for (int i = 1; i < pop_cyc.size(); i++) begin
      tests_run++;
      if (pop_cyc[i] != pop_cyc[0] + i) begin
        tests_failed++; $display("FAIL stream_pop_rate[%0d]: offset %0d want %0d", i, pop_cyc[i] - pop_cyc[0], i); end
    end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL stream_drained: %0d left want 0", exp_q.size()); end
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL stream_idle: req=%b want 0", imem_req); end
  endtask

  task automatic test_backpressure();
    bit found;
    do_reset();
    mem_delay = 0;
    en = 1'b1; instr_ready = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++; if (fifo_count !== 3'd4) begin tests_failed++; $display("FAIL bp_full_count: got %0d want 4", fifo_count); end
    tests_run++; if (imem_req !== 1'b0)   begin tests_failed++; $display("FAIL bp_req_low: got %b want 0", imem_req); end
    tests_run++; if (req_log.size() != 4) begin tests_failed++; $display("FAIL bp_nreq: got %0d want 4", req_log.size()); end
    tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0000) begin
      tests_failed++; $display("FAIL bp_head: valid=%b pc=%h want 1/0000", instr_valid, instr_pc); end
    for (int i = 0; i < 20; i++) exp_q.push_back(16'(i));
    instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && imem_addr === 16'h0004) found = 1'b1;
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL bp_resume: no request to 0004 seen, last addr=%h", imem_addr); end
    repeat (6) @(negedge clk);
    en = 1'b0;
    repeat (12) @(negedge clk);
    tests_run++; if (req_log.size() <= 4 || req_log[4] !== 16'h0004) begin
      tests_failed++; $display("FAIL bp_resume_log: nreq=%0d want >4 with 5th addr 0004", req_log.size()); end
    tests_run++; if (n_pops != req_log.size()) begin
      tests_failed++; $display("FAIL bp_all_drained: pops=%0d want %0d", n_pops, req_log.size()); end
    exp_q.delete();
  endtask

  task automatic test_branch_discard();
    bit found;
    do_reset();
    mem_delay = 3;
    for (int i = 0; i < 5; i++)  exp_q.push_back(16'(i));
    for (int i = 0; i < 16; i++) exp_q.push_back(16'h0100 + 16'(i));
    en = 1'b1; instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && imem_addr === 16'h0005) found = 1'b1;
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL disc_reach5: no request to 0005, addr=%h", imem_addr); end
    @(negedge clk);
    br_taken = 1'b1; br_target = 16'h0100;
    @(negedge clk);
    br_taken = 1'b0;
    tests_run++; if (fifo_count !== 3'd0 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL disc_flush: count=%0d valid=%b want 0/0", fifo_count, instr_valid); end
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin
      tests_failed++; $display("FAIL disc_req_held: req=%b addr=%h want 1/0005", imem_req, imem_addr); end
    repeat (2) @(negedge clk);
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL disc_idle_after_ack: req=%b want 0", imem_req); end
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
      tests_failed++; $display("FAIL disc_new_req: req=%b addr=%h want 1/0100", imem_req, imem_addr); end
    repeat (12) @(negedge clk);
    en = 1'b0;
    repeat (12) @(negedge clk);
    tests_run++; if (req_log.size() < 7 || req_log[5] !== 16'h0005 || req_log[6] !== 16'h0100) begin
      tests_failed++; $display("FAIL disc_log: nreq=%0d want >=7 with 0005 then 0100", req_log.size()); end
    tests_run++; if (n_pops != req_log.size() - 1) begin
      tests_failed++; $display("FAIL disc_dropped: pops=%0d want %0d", n_pops, req_log.size() - 1); end
    exp_q.delete();
  endtask

  task automatic test_branch_ack_pop();
    do_reset();
    mem_delay = 0;
    for (int i = 0; i < 4; i++)  exp_q.push_back(16'(i));
    for (int i = 0; i < 16; i++) exp_q.push_back(16'h0040 + 16'(i));
    en = 1'b1; instr_ready = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004 || instr_valid !== 1'b1 || instr_pc !== 16'h0003) begin
      tests_failed++; $display("FAIL bap_setup: req=%b addr=%h valid=%b pc=%h want 1/0004/1/0003", imem_req, imem_addr, instr_valid, instr_pc); end
    br_taken = 1'b1; br_target = 16'h0040;
    @(negedge clk);
    br_taken = 1'b0;
    tests_run++; if (instr_valid !== 1'b0 || fifo_count !== 3'd0) begin
      tests_failed++; $display("FAIL bap_flush: valid=%b count=%0d want 0/0", instr_valid, fifo_count); end
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL bap_idle: req=%b want 0", imem_req); end
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      tests_failed++; $display("FAIL bap_new_req: req=%b addr=%h want 1/0040", imem_req, imem_addr); end
    repeat (6) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++; if (req_log.size() < 6 || req_log[4] !== 16'h0004 || req_log[5] !== 16'h0040) begin
      tests_failed++; $display("FAIL bap_log: nreq=%0d want >=6 with 0004 then 0040", req_log.size()); end
    tests_run++; if (n_pops != req_log.size() - 1) begin
      tests_failed++; $display("FAIL bap_dropped: pops=%0d want %0d", n_pops, req_log.size() - 1); end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    logic [15:0] wa;
    do_reset();
    mem_delay = 0;
    for (int i = 0; i < 20; i++) exp_q.push_back(16'(i));
    en = 1'b1; instr_ready = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j <= 4) begin
        wa = 16'hFFFE + 16'(j - 1);
        tests_run++; if (w_req !== 1'b1 || w_addr !== wa) begin
          tests_failed++; $display("FAIL wrap_addr[%0d]: req=%b addr=%h want 1/%h", j, w_req, w_addr, wa); end
      end
      if (j >= 2) begin
        wa = 16'hFFFE + 16'(j - 2);
        tests_run++; if (w_valid !== 1'b1 || w_pc !== wa || w_instr !== mem_word(wa)) begin
          tests_failed++; $display("FAIL wrap_out[%0d]: valid=%b pc=%h instr=%h want 1/%h/%h", j, w_valid, w_pc, w_instr, wa, mem_word(wa)); end
      end
    end
    en = 1'b0;
    repeat (8) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_en_drop_and_reset();
    bit found;
    do_reset();
    mem_delay = 3;
    exp_q.push_back(16'h0000);
    en = 1'b1; instr_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && imem_addr === 16'h0000) found = 1'b1;
    end
    en = 1'b0;
    tests_run++; if (!found) begin tests_failed++; $display("FAIL endrop_req: no request to 0000, req=%b", imem_req); end
    repeat (10) @(negedge clk);
    tests_run++; if (req_log.size() != 1 || n_pops != 1) begin
      tests_failed++; $display("FAIL endrop_word: nreq=%0d pops=%0d want 1/1", req_log.size(), n_pops); end
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL endrop_no_req: req=%b want 0", imem_req); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL endrop_drained: %0d left want 0", exp_q.size()); end

    mem_auto = 1'b0;
    @(negedge clk);
    imem_ack = 1'b0;
    en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1 && imem_addr === 16'h0001) found = 1'b1;
    end
    tests_run++; if (!found) begin tests_failed++; $display("FAIL rstreq_setup: no request to 0001, addr=%h", imem_addr); end
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hDEAD; en = 1'b0;
    @(negedge clk);
    tests_run++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin
      tests_failed++; $display("FAIL rstreq_drop: req=%b addr=%h want 0/0000", imem_req, imem_addr); end
    tests_run++; if (fifo_count !== 3'd0 || instr_valid !== 1'b0) begin
      tests_failed++; $display("FAIL rstreq_fifo: count=%0d valid=%b want 0/0", fifo_count, instr_valid); end
    rst = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    tests_run++; if (fifo_count !== 3'd0 || imem_req !== 1'b0 || req_log.size() != 1) begin
      tests_failed++; $display("FAIL rstreq_ack_ignored: count=%0d req=%b nreq=%0d want 0/0/1", fifo_count, imem_req, req_log.size()); end
    mem_auto = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; br_taken = 1'b0; br_target = '0; instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_discard();
    test_branch_ack_pop();
    test_wrap();
    test_en_drop_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch sequencer for the accumulator CPU.
- Maintains the fetch PC and issues single-outstanding requests to instruction memory over a req/ack handshake.
- Buffers returned words with their PCs in a DEPTH-entry prefetch FIFO, and presents them to decode via valid/ready.
- Handles taken branches by flushing the FIFO and discarding any in-flight return.

Parameters:
PC_W, 16, program-counter/address width; word-addressed
INSTR_W, 16, instruction word width
DEPTH, 4, prefetch FIFO entries; power of two, >=2
RESET_PC, 0, fetch PC loaded on reset

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  fetch enable; 0 = issue no new requests
br_taken  in  1  redirect pulse from execute, sampled each cycle
br_target  in  PC_W  redirect address, valid with br_taken
imem_req  out  1  memory request, registered
imem_addr  out  PC_W  request address, registered, stable while imem_req=1
imem_ack  in  1  memory response strobe; meaningful only while imem_req=1
imem_rdata  in  INSTR_W  instruction word, valid with imem_ack
instr_valid  out  1  FIFO head valid (count!=0)
instr_ready  in  1  decode accepts head
instr  out  INSTR_W  FIFO head word
instr_pc  out  PC_W  PC of FIFO head word
fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst=1 at edge, overrides everything): fetch_pc=RESET_PC, FIFO empty, fifo_count=0, instr_valid=0, imem_req=0, imem_addr=RESET_PC, FSM=IDLE. Reset mid-request drops the request; any ack arriving in the reset cycle is ignored.
- FSM states and transitions:
  - IDLE→REQ when en=1, br_taken=0 and fifo_count<DEPTH (one slot reserved for the outstanding word). On this transition: imem_req<=1 and imem_addr<=fetch_pc.
  - REQ: imem_req and imem_addr held until imem_ack=1. The memory may ack in the first cycle imem_req is high.
    - On ack: push {fetch_pc, imem_rdata}, fetch_pc<=fetch_pc+1 (mod 2^PC_W, 0xFFFF→0x0000 at default).
    - After ack, when en=1 and room remains after the push, go straight back to REQ with the next address, with no bubble: imem_req stays 1 and imem_addr updates. Otherwise imem_req<=0 and go to IDLE.
  - DISCARD: an outstanding request is invalidated. imem_req is held high until imem_ack, the ack data is dropped, then the FSM returns to IDLE.
- Branch (br_taken=1):
  - FIFO is flushed (count<=0) and fetch_pc<=br_target, both next edge.
  - State REQ with no ack in the same cycle → DISCARD. A request is never retracted.
  - Ack in the same cycle as br_taken → data dropped, go to IDLE.
  - Branch in IDLE → stay IDLE. The first request to br_target issues the following cycle.
  - Branch while in DISCARD → new target latched, stay in DISCARD.
  - A pop in the same cycle as br_taken is accepted by decode, but the flush wins. instr_valid=0 next cycle.
- FIFO:
  - Head is visible combinationally from storage.
  - Pop when instr_valid & instr_ready. A pop and a push in the same cycle leave the count unchanged.
  - Pop while empty is ignored.
  - Overflow cannot occur because of slot reservation. The bench asserts fifo_count<=DEPTH.
- en=0: no new request issues. An outstanding request completes and its word is pushed. The FIFO keeps draining.
- Latency: request issued one cycle after the issue condition. With a same-cycle ack, the word is visible at the FIFO head the cycle after the ack. Branch→first request at br_target takes 1 cycle from IDLE, or 1 cycle after the discarded ack.

Test Plan:
- Reset, en=1, memory acks same cycle, instr_ready=1: imem_addr sequence 0,1,2,3… on consecutive cycles; instr/instr_pc pairs arrive in order, one per cycle after a 2-cycle startup.
- instr_ready=0, en=1: exactly DEPTH=4 requests complete, fifo_count=4, imem_req=0. Raise ready: entries 0..3 drain in order and fetch resumes at addr 4.
- Memory ack delayed 3 cycles, br_taken with target 0x0100 asserted 1 cycle after request to addr 5: req stays high until ack, word 5 is not pushed, fifo_count=0, next imem_addr=0x0100, instr_pc of first output=0x0100.
- br_taken (target 0x0040) in the same cycle as ack and pop: ack data dropped, instr_valid=0 next cycle, next request addr 0x0040.
- RESET_PC=0xFFFE, free-running: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, with instr_pc matching.
- en dropped during outstanding request: that word is pushed, no further imem_req; rst asserted while in REQ: imem_req=0 and FIFO empty next cycle, with the late ack ignored.
